// File: rtl/edge_event_encoder_pkg.sv
// rtl/edge_event_encoder_pkg.sv - shared state encoding and tdata field layout
//
// Purpose: FSM state encoding and tdata field offsets for edge_event_encoder.
// Ports:   none (package)
package edge_event_encoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // tdata layout, MSB to LSB: {lost, 1'b0, channel, timestamp}
  localparam int TS_LSB = 0;

  function automatic int ch_lsb(input int ts_w);
    return TS_LSB + ts_w;
  endfunction

  function automatic int lost_bit(input int ch_w, input int ts_w);
    return ts_w + ch_w + 1;
  endfunction

endpackage

// File: rtl/edge_priority_encoder.sv
// rtl/edge_priority_encoder.sv - lowest-set-bit index encoder
//
// Purpose: combinational encoder; returns the index of the lowest set bit.
// Ports:
//   vec    in   2**CH_WIDTH   request vector
//   idx    out  CH_WIDTH      index of lowest set bit (0 when vec is zero)
//   valid  out  1             vec is non-zero
module edge_priority_encoder #(
  parameter int CH_WIDTH = 6
) (
  input  logic [(2**CH_WIDTH)-1:0] vec,
  output logic [CH_WIDTH-1:0]      idx,
  output logic                     valid
);

  localparam int CHANNELS = 2 ** CH_WIDTH;

  // Scan high to low so the last (lowest) hit wins.
  always_comb begin
    idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (vec[i]) idx = CH_WIDTH'(i);
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/edge_event_encoder.sv
// rtl/edge_event_encoder.sv - time-stamps edge-pulse batches and serialises them to a stream
//
// Purpose: captures non-zero pulse vectors with a free-running timestamp and
//          emits one stream word per set channel, lowest channel first.
// Ports:
//   aclk           in   1                  clock
//   areset         in   1                  async reset, active-high
//   cfg_enable     in   1                  capture enable (drain continues when low)
//   din            in   2**CH_WIDTH        one-cycle event pulses
//   sts_busy       out  1                  batch pending
//   sts_lost       out  32                 saturating count of cycles with dropped events
//   m_axis_tdata   out  AXIS_TDATA_WIDTH   {lost, 1'b0, channel, timestamp}
//   m_axis_tvalid  out  1                  word valid
//   m_axis_tready  in   1                  downstream ready
module edge_event_encoder
  import edge_event_encoder_pkg::*;
#(
  parameter int CH_WIDTH         = 6,
  parameter int TS_WIDTH         = 56,
  parameter int AXIS_TDATA_WIDTH = 64
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cfg_enable,
  input  logic [(2**CH_WIDTH)-1:0]    din,
  output logic                        sts_busy,
  output logic [31:0]                 sts_lost,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
);

  localparam int CHANNELS = 2 ** CH_WIDTH;
  localparam int CH_LSB   = ch_lsb(TS_WIDTH);
  localparam int LOST_BIT = lost_bit(CH_WIDTH, TS_WIDTH);

  generate
    if (AXIS_TDATA_WIDTH != 2 + CH_WIDTH + TS_WIDTH) begin : g_width_check
      $error("edge_event_encoder: AXIS_TDATA_WIDTH must equal 2+CH_WIDTH+TS_WIDTH");
    end
  endgenerate

  state_t                state;
  logic [TS_WIDTH-1:0]   ts;
  logic [CHANNELS-1:0]   pend;
  logic [TS_WIDTH-1:0]   bts;
  logic                  blost;
  logic                  lost_sticky;

  logic [CHANNELS-1:0]   ev;
  logic [CH_WIDTH-1:0]   ch;
  logic                  pend_valid;
  logic [CHANNELS-1:0]   pend_after;
  logic                  hs;
  logic                  final_hs;

  edge_priority_encoder #(.CH_WIDTH(CH_WIDTH)) u_prio (
    .vec   (pend),
    .idx   (ch),
    .valid (pend_valid)
  );

  assign ev         = din & {CHANNELS{cfg_enable}};
  assign hs         = (state == DRAIN) && pend_valid && m_axis_tready;
  assign pend_after = pend & ~(CHANNELS'(1) << ch);
  assign final_hs   = hs && (pend_after == '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ts          <= '0;
      state       <= IDLE;
      pend        <= '0;
      bts         <= '0;
      blost       <= 1'b0;
      lost_sticky <= 1'b0;
      sts_lost    <= '0;
    end else begin
      ts <= ts + TS_WIDTH'(1);
      case (state)
        IDLE: begin
          if (ev != '0) begin
            pend        <= ev;
            bts         <= ts;
            blost       <= lost_sticky;
            lost_sticky <= 1'b0;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (hs) begin
            pend  <= pend_after;
            blost <= 1'b0;
            if (final_hs) begin
              // A batch arriving on the final handshake is taken without a gap.
              if (ev != '0) begin
                pend        <= ev;
                bts         <= ts;
                blost       <= lost_sticky;
                lost_sticky <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end
          end
          if ((ev != '0) && !final_hs) begin
            lost_sticky <= 1'b1;
            if (sts_lost != 32'hFFFF_FFFF) sts_lost <= sts_lost + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_axis_tdata                      = '0;
    m_axis_tdata[LOST_BIT]            = blost;
    m_axis_tdata[CH_LSB +: CH_WIDTH]  = ch;
    m_axis_tdata[TS_LSB +: TS_WIDTH]  = bts;
  end

  assign m_axis_tvalid = (state == DRAIN);
  assign sts_busy      = (state == DRAIN);

endmodule
